// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

   // Opcode field values (instr[6:0])
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] BR     = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] HALT   = 7'b1111111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   // Controller states; the encoding is exported on state_dbg
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6,
      StErr    = 3'd7
   } state_e;

   localparam logic [1:0] ALU_OP_ADD  = 2'b00;
   localparam logic [1:0] ALU_OP_BR   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNC = 2'b10;
   localparam logic [1:0] ALU_OP_PASS = 2'b11;

   localparam logic [1:0] PC_SEL_PC4    = 2'b00;
   localparam logic [1:0] PC_SEL_TARGET = 2'b01;
   localparam logic [1:0] PC_SEL_ALU    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   // True for opcodes the controller can execute (HALT is handled separately)
   function automatic logic is_legal(input logic [6:0] op, input logic utype_en);
      case (op)
         R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR: is_legal = 1'b1;
         LUI, AUIPC:                            is_legal = utype_en;
         default:                               is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles and flags a timeout.
module mem_watchdog #(
   parameter int unsigned WAIT_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,   // controller is waiting on memory this cycle
   input  logic ready,    // memory completes this cycle
   input  logic clear,    // controller changes state this cycle
   output logic timeout
);

   localparam logic [WAIT_W-1:0] MAX_CNT = {WAIT_W{1'b1}};

   logic [WAIT_W-1:0] count_q, count_d;

   // Timeout fires on the stall that would bring the count to MAX_CNT; ready wins
   assign timeout = active && !ready && (count_q == (MAX_CNT - WAIT_W'(1)));

   // Next count: restart on ready, idle or state change, otherwise saturate upward
   always_comb begin
      count_d = count_q;
      if (!active || ready || clear) begin
         count_d = '0;
      end else if (count_q != MAX_CNT) begin
         count_d = count_q + WAIT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory watchdog.
module multicycle_controller
   import rv_ctrl_pkg::*;
#(
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter bit          UTYPE_EN      = 1'b0,
   parameter int unsigned WAIT_W        = 4,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       instr_opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_sel,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state_dbg
);

   state_e           state_q, state_d;
   logic [6:0]       opcode_q, opcode_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;
   logic             ready;
   logic             wd_active;
   logic             timeout;

   // Without a handshake, memory is treated as always completing in one cycle
   assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign wd_active = MEM_HANDSHAKE && ((state_q == StFetch) || (state_q == StMem));

   mem_watchdog #(
      .WAIT_W (WAIT_W)
   ) u_mem_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (wd_active),
      .ready   (ready),
      .clear   (state_d != state_q),
      .timeout (timeout)
   );

   // Next-state and Moore-style control decode from state plus latched opcode
   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_sel        = PC_SEL_PC4;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALU_OP_ADD;

      unique case (state_q)
         StIdle: state_d = StFetch;

         StFetch: begin
            mem_read = 1'b1;
            if (ready) begin
               ir_write = 1'b1;
               opcode_d = instr_opcode;
               state_d  = StDecode;
            end else if (timeout) begin
               state_d = StErr;
            end
         end

         StDecode: begin
            if (opcode_q == HALT) begin
               state_d = StHalt;
            end else if (is_legal(opcode_q, UTYPE_EN)) begin
               state_d = StExec;
            end else begin
               state_d = StErr;
            end
         end

         StExec: begin
            case (opcode_q)
               R_TYPE: begin
                  alu_src_b = SRC_B_RS2;
                  alu_op    = ALU_OP_FUNC;
                  state_d   = StWb;
               end
               I_TYPE: begin
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_OP_FUNC;
                  state_d   = StWb;
               end
               LW, SW: begin
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_OP_ADD;
                  state_d   = StMem;
               end
               BR: begin
                  alu_op        = ALU_OP_BR;
                  pc_write_cond = 1'b1;
                  pc_sel        = PC_SEL_TARGET;
                  retire        = 1'b1;
                  state_d       = StFetch;
               end
               JAL: begin
                  pc_write  = 1'b1;
                  pc_sel    = PC_SEL_TARGET;
                  reg_write = 1'b1;
                  retire    = 1'b1;
                  state_d   = StFetch;
               end
               JALR: begin
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_OP_FUNC;
                  pc_sel    = PC_SEL_ALU;
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  retire    = 1'b1;
                  state_d   = StFetch;
               end
               LUI: begin
                  alu_op    = ALU_OP_PASS;
                  alu_src_b = SRC_B_IMM;
                  state_d   = StWb;
               end
               AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRC_B_IMM;
                  alu_op    = ALU_OP_ADD;
                  state_d   = StWb;
               end
               default: state_d = StErr;
            endcase
         end

         StMem: begin
            iord      = 1'b1;
            mem_read  = (opcode_q == LW);
            mem_write = (opcode_q == SW);
            if (ready) begin
               if (opcode_q == LW) begin
                  state_d = StWb;
               end else begin
                  pc_write = 1'b1;
                  pc_sel   = PC_SEL_PC4;
                  retire   = 1'b1;
                  state_d  = StFetch;
               end
            end else if (timeout) begin
               state_d = StErr;
            end
         end

         StWb: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode_q == LW);
            pc_write   = 1'b1;
            pc_sel     = PC_SEL_PC4;
            retire     = 1'b1;
            state_d    = StFetch;
         end

         // HALT and ERR are terminal until reset; all strobes stay low
         StHalt:  state_d = StHalt;
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   // State, opcode latch and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         opcode_q  <= '0;
         retired_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   assign halted    = (state_q == StHalt);
   assign error     = (state_q == StErr);
   assign retired   = retired_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_HALT = 7'b1111111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  instr_opcode;
   logic        mem_ready;

   logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
   logic        mem_to_reg, reg_write, alu_src_a, halted, error;
   logic [1:0]  pc_sel, alu_src_b, alu_op;
   logic [31:0] retired;
   logic [2:0]  state_dbg;

   logic        u_pc_write, u_pc_write_cond, u_ir_write, u_iord, u_mem_read, u_mem_write;
   logic        u_mem_to_reg, u_reg_write, u_alu_src_a, u_halted, u_error;
   logic [1:0]  u_pc_sel, u_alu_src_b, u_alu_op;
   logic [31:0] u_retired;
   logic [2:0]  u_state_dbg;

   logic [14:0] ctl, u_ctl;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   multicycle_controller #(
      .MEM_HANDSHAKE (1'b1),
      .UTYPE_EN      (1'b0),
      .WAIT_W        (4),
      .CNT_W         (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_opcode  (instr_opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_sel        (pc_sel),
      .ir_write      (ir_write),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .halted        (halted),
      .error         (error),
      .retired       (retired),
      .state_dbg     (state_dbg)
   );

   multicycle_controller #(
      .MEM_HANDSHAKE (1'b1),
      .UTYPE_EN      (1'b1),
      .WAIT_W        (4),
      .CNT_W         (32)
   ) dut_u (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_opcode  (instr_opcode),
      .mem_ready     (mem_ready),
      .pc_write      (u_pc_write),
      .pc_write_cond (u_pc_write_cond),
      .pc_sel        (u_pc_sel),
      .ir_write      (u_ir_write),
      .iord          (u_iord),
      .mem_read      (u_mem_read),
      .mem_write     (u_mem_write),
      .mem_to_reg    (u_mem_to_reg),
      .reg_write     (u_reg_write),
      .alu_src_a     (u_alu_src_a),
      .alu_src_b     (u_alu_src_b),
      .alu_op        (u_alu_op),
      .halted        (u_halted),
      .error         (u_error),
      .retired       (u_retired),
      .state_dbg     (u_state_dbg)
   );

   assign ctl = {pc_write, pc_write_cond, pc_sel, ir_write, iord, mem_read, mem_write,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
   assign u_ctl = {u_pc_write, u_pc_write_cond, u_pc_sel, u_ir_write, u_iord, u_mem_read,
                   u_mem_write, u_mem_to_reg, u_reg_write, u_alu_src_a, u_alu_src_b, u_alu_op};

   // Expected control bundle, fields in the same order as ctl
   function automatic logic [14:0] mk(input logic pw, input logic pwc, input logic [1:0] ps,
                                      input logic irw, input logic io, input logic mr,
                                      input logic mw, input logic m2r, input logic rw,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop);
      return {pw, pwc, ps, irw, io, mr, mw, m2r, rw, asa, asb, aop};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n        = 1'b0;
      mem_ready    = 1'b0;
      instr_opcode = '0;
      repeat (2) step();

      // Reset state
      check("rst_state",   64'(state_dbg), 64'd0);
      check("rst_ctl",     64'(ctl),       64'd0);
      check("rst_retired", 64'(retired),   64'd0);
      check("rst_flags",   64'({halted, error}), 64'd0);

      rst_n = 1'b1;
      step();
      check("fetch_state", 64'(state_dbg), 64'd1);
      check("fetch_wait",  64'(ctl), 64'(mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));

      // ADD with single-cycle memory
      mem_ready    = 1'b1;
      instr_opcode = OP_ADD;
      #1;
      check("fetch_ready", 64'(ctl), 64'(mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
      step();
      check("add_dec_state", 64'(state_dbg), 64'd2);
      check("add_dec_ctl",   64'(ctl), 64'd0);
      step();
      check("add_exec_state", 64'(state_dbg), 64'd3);
      check("add_exec_ctl", 64'(ctl), 64'(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10)));
      step();
      check("add_wb_state", 64'(state_dbg), 64'd5);
      check("add_wb_ctl", 64'(ctl), 64'(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00)));
      check("add_wb_retired", 64'(retired), 64'd0);
      step();
      check("add_done_state", 64'(state_dbg), 64'd1);
      check("add_retired",    64'(retired),   64'd1);

      // LW with ready delayed three cycles in MEM
      instr_opcode = OP_LW;
      step();
      step();
      check("lw_exec_ctl", 64'(ctl), 64'(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00)));
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check("lw_mem_stall_state", 64'(state_dbg), 64'd4);
         check("lw_mem_stall_ctl", 64'(ctl),
               64'(mk(0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
         step();
      end
      mem_ready = 1'b1;
      check("lw_mem_last_state", 64'(state_dbg), 64'd4);
      check("lw_mem_last_ctl", 64'(ctl), 64'(mk(0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
      step();
      check("lw_wb_state", 64'(state_dbg), 64'd5);
      check("lw_wb_ctl", 64'(ctl), 64'(mk(1, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00)));
      step();
      check("lw_retired", 64'(retired), 64'd2);

      // Asynchronous reset in the middle of a stalled LW MEM phase
      instr_opcode = OP_LW;
      step();
      step();
      mem_ready = 1'b0;
      step();
      step();
      check("rst_mid_pre_state", 64'(state_dbg), 64'd4);
      rst_n = 1'b0;
      #1;
      check("rst_mid_state",   64'(state_dbg), 64'd0);
      check("rst_mid_ctl",     64'(ctl),       64'd0);
      check("rst_mid_retired", 64'(retired),   64'd0);
      step();
      rst_n = 1'b1;
      step();
      check("rst_mid_fetch", 64'(state_dbg), 64'd1);

      // FETCH watchdog: 15 stalled cycles then ERR
      repeat (14) step();
      check("wd_14_state", 64'(state_dbg), 64'd1);
      check("wd_14_error", 64'(error),     64'd0);
      step();
      check("wd_err_state",   64'(state_dbg), 64'd7);
      check("wd_err_flag",    64'(error),     64'd1);
      check("wd_err_ctl",     64'(ctl),       64'd0);
      check("wd_err_retired", 64'(retired),   64'd0);
      mem_ready = 1'b1;
      repeat (3) step();
      check("wd_err_sticky", 64'({state_dbg, error}), 64'({3'd7, 1'b1}));

      // LUI: illegal without UTYPE_EN, pass-immediate with it
      do_reset();
      check("lui_fetch", 64'({state_dbg, u_state_dbg}), 64'({3'd1, 3'd1}));
      instr_opcode = OP_LUI;
      step();
      step();
      check("lui_off_err",   64'({state_dbg, error}), 64'({3'd7, 1'b1}));
      check("lui_on_exec",   64'(u_state_dbg), 64'd3);
      check("lui_on_ctl", 64'(u_ctl), 64'(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b11)));
      step();
      check("lui_on_wb", 64'(u_ctl), 64'(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00)));
      check("lui_off_stay", 64'(state_dbg), 64'd7);
      step();
      check("lui_on_retired", 64'(u_retired), 64'd1);

      // BR, JAL, then HALT
      do_reset();
      instr_opcode = OP_BR;
      step();
      step();
      check("br_exec_ctl", 64'(ctl), 64'(mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)));
      step();
      check("br_retired", 64'({state_dbg, retired}), 64'({3'd1, 32'd1}));
      instr_opcode = OP_JAL;
      step();
      step();
      check("jal_exec_ctl", 64'(ctl), 64'(mk(1, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00)));
      step();
      check("jal_retired", 64'({state_dbg, retired}), 64'({3'd1, 32'd2}));
      instr_opcode = OP_HALT;
      step();
      step();
      check("halt_state", 64'({state_dbg, halted, error}), 64'({3'd6, 1'b1, 1'b0}));
      check("halt_ctl",   64'(ctl), 64'd0);
      repeat (3) step();
      check("halt_sticky",  64'({state_dbg, halted}), 64'({3'd6, 1'b1}));
      check("halt_retired", 64'(retired), 64'd2);
      check("halt_quiet",   64'(ctl),     64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
